icache_line_ctrl: RTL and testbench
===================================

# icache_line_ctrl

Read-only, direct-mapped cache controller sitting between the CPU instruction-fetch Avalon-MM master and the system memory Avalon-MM slave. Owns the line storage, tag and valid arrays and the lookup/refill state machine. Extracts the requested 32-bit word from the selected line using the set index and word offset. Fills missing lines with a single Avalon burst.

## Interface
- log_of_number_of_sets, 2, log2 of line count; index = s_address[bits_for_offset +: log_of_number_of_sets]
- bits_for_offset, 3, log2 of line size in bytes; must be >= 2; words per line W = 2**(bits_for_offset-2)
- tag width T = 32 - bits_for_offset - log_of_number_of_sets (derived, not overridable)
- clk  in  1  sole clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- s_address  in  32  CPU byte address; bits [1:0] ignored
- s_read  in  1  CPU read request; held by the CPU until s_waitrequest is low
- s_waitrequest  out  1  high while the request is not yet served
- s_readdata  out  32  read word; valid in the cycle s_waitrequest is low
- invalidate  in  1  single-cycle pulse; clears all valid bits
- m_address  out  32  line-aligned refill address (low bits_for_offset bits zero)
- m_read  out  1  refill burst request
- m_burstcount  out  8  constant W while m_read is high
- m_waitrequest  in  1  memory stall of the command phase
- m_readdata  in  32  refill beat data
- m_readdatavalid  in  1  refill beat strobe

## Operation
- States: IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESP.
- IDLE: when s_read=1, capture s_address into addr_q and go to LOOKUP.
- LOOKUP: compare valid[idx] and tag[idx] with addr_q.
  - Hit -> RESP.
  - Miss -> MISS_REQ; clear valid[idx] and reset the beat counter to 0.
- MISS_REQ: assert m_read with m_address = {addr_q[31:bits_for_offset], 0} and m_burstcount=W.
  - Hold the command until m_waitrequest=0.
  - In the cycle the command is accepted, deassert m_read and go to MISS_FILL.
- MISS_FILL: on each m_readdatavalid, write m_readdata into word[beat] of line idx and increment beat.
  - On the W-th beat, set valid[idx]=1 and tag[idx]=addr_q tag, then go to RESP.
  - Beats arriving in any other state are ignored.
- RESP: s_waitrequest=0 for exactly one cycle, then IDLE.
  - s_readdata = word addr_q[bits_for_offset-1:2] of line idx, registered on entry to RESP.
- s_waitrequest = 1 in every state except RESP, including during reset.
- invalidate:
  - In IDLE or RESP, all valid bits clear at the next edge.
  - In LOOKUP, MISS_REQ or MISS_FILL, a pending flag is set instead. The current refill completes and responds normally. The pending flag clears all valid bits, itself included, on the first cycle back in IDLE.
  - If invalidate coincides with the final refill beat, that line's valid is still cleared via the pending flag.
- A new s_read seen in the IDLE cycle immediately after RESP is accepted; back-to-back hits cost 3 cycles each.

## Timing
- Reset (reset_n=0 at an edge):
  - state=IDLE; all valid=0; pending flag=0; beat=0.
  - m_read=0; m_address=0; m_burstcount=0; s_readdata=0.
  - Line storage and tags are not reset.
- Reset mid-refill abandons the burst. Late beats arriving after reset are ignored, because in IDLE the block discards all m_readdatavalid.
- Hit latency: s_read sampled at edge 0 -> LOOKUP at edge 1 -> s_waitrequest low in cycle after edge 2.
- Miss latency: 2 + command stall + beat arrival time + 1 cycles, with the response one cycle after the last beat.
- Registered outputs: m_read, m_address, m_burstcount, s_readdata. s_waitrequest is decoded from state only, never from inputs.
- Beat counter width = max(1, bits_for_offset-2). It wraps only via the explicit reset on a miss.

## Test plan
- Cold miss, defaults: read 0x0000_0104 after reset.
  - Expect m_read with m_address=0x0000_0100 and m_burstcount=2.
  - Return beats 0xAAAA_0000 and 0xBBBB_0004.
  - s_readdata=0xBBBB_0004 one cycle after the 2nd beat.
- Hit: then read 0x0000_0100 -> no m_read; s_waitrequest low in the 3rd cycle; data 0xAAAA_0000.
- Conflict: read 0x0000_0120 (same index 0, new tag) -> refill burst at 0x0000_0120. A following read of 0x0000_0100 misses again.
- Memory stall: hold m_waitrequest=1 for 5 cycles during MISS_REQ.
  - m_read and m_address stay stable throughout.
  - Exactly one burst is issued.
  - The response follows the last beat by 1 cycle.
- Invalidate: pulse invalidate during MISS_FILL of line 1.
  - The refill response still returns the correct word.
  - The next read of that address misses, as do all other previously filled lines.
- Reset mid-refill: assert reset_n=0 after 1 of 2 beats, deliver the 2nd beat during and after reset.
  - All outputs at their reset values; s_waitrequest=1.
  - A re-read of the same address issues a fresh burst.

Source files
------------

// File: rtl/icache_line_ctrl.sv
// Direct-mapped read-only I-cache: hit responds 3 cycles after s_read, miss refills one line by a W-beat burst.
// CPU is held on s_waitrequest until RESP; memory command stalls via m_waitrequest, beats via m_readdatavalid.
module icache_line_ctrl #(
    parameter int log_of_number_of_sets = 2,
    parameter int bits_for_offset       = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s_address,
    input  logic        s_read,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    input  logic        invalidate,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic [7:0]  m_burstcount,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid
);
    localparam int SETS   = 1 << log_of_number_of_sets;
    localparam int WORDS  = 1 << (bits_for_offset - 2);
    localparam int TAG_W  = 32 - bits_for_offset - log_of_number_of_sets;
    localparam int BEAT_W = (bits_for_offset > 3) ? bits_for_offset - 2 : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_FILL,
        RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [SETS-1:0]           valid_q, valid_d;
    logic                      pend_q, pend_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      m_read_q, m_read_d;
    logic [31:0]               m_address_q, m_address_d;
    logic [7:0]                m_burstcount_q, m_burstcount_d;
    logic [31:0]               s_readdata_q, s_readdata_d;
    logic [WORDS-1:0][31:0]    data_q [SETS];
    logic [WORDS-1:0][31:0]    data_d [SETS];
    logic [TAG_W-1:0]          tag_q  [SETS];
    logic [TAG_W-1:0]          tag_d  [SETS];

    logic [log_of_number_of_sets-1:0] idx;
    logic [TAG_W-1:0]                 addr_tag;
    logic [BEAT_W-1:0]                word_off;
    logic                             hit;
    logic                             last_beat;

    always_comb begin
        idx       = addr_q[bits_for_offset +: log_of_number_of_sets];
        addr_tag  = addr_q[31 -: TAG_W];
        word_off  = (WORDS > 1) ? BEAT_W'(addr_q >> 2) : '0;
        hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
        last_beat = (beat_q == BEAT_W'(WORDS - 1));
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        valid_d        = valid_q;
        pend_d         = pend_q;
        beat_d         = beat_q;
        m_read_d       = m_read_q;
        m_address_d    = m_address_q;
        m_burstcount_d = m_burstcount_q;
        s_readdata_d   = s_readdata_q;
        data_d         = data_q;
        tag_d          = tag_q;

        case (state_q)
            IDLE: begin
                if (pend_q || invalidate) begin
                    valid_d = '0;
                    pend_d  = 1'b0;
                end
                if (s_read) begin
                    addr_d  = s_address;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (invalidate) pend_d = 1'b1;
                if (hit) begin
                    s_readdata_d = data_q[idx][word_off];
                    state_d      = RESP;
                end else begin
                    valid_d[idx]   = 1'b0;
                    beat_d         = '0;
                    m_read_d       = 1'b1;
                    m_address_d    = {addr_q[31:bits_for_offset], {bits_for_offset{1'b0}}};
                    m_burstcount_d = 8'(WORDS);
                    state_d        = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (invalidate) pend_d = 1'b1;
                if (!m_waitrequest) begin
                    m_read_d       = 1'b0;
                    m_burstcount_d = 8'd0;
                    state_d        = MISS_FILL;
                end
            end
            MISS_FILL: begin
                if (invalidate) pend_d = 1'b1;
                if (m_readdatavalid) begin
                    data_d[idx][beat_q] = m_readdata;
                    if (last_beat) begin
                        valid_d[idx] = 1'b1;
                        tag_d[idx]   = addr_tag;
                        // The requested word may be the beat arriving now, not yet in storage.
                        s_readdata_d = (word_off == beat_q) ? m_readdata : data_q[idx][word_off];
                        state_d      = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (invalidate) valid_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            valid_q        <= '0;
            pend_q         <= 1'b0;
            beat_q         <= '0;
            m_read_q       <= 1'b0;
            m_address_q    <= '0;
            m_burstcount_q <= '0;
            s_readdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            valid_q        <= valid_d;
            pend_q         <= pend_d;
            beat_q         <= beat_d;
            m_read_q       <= m_read_d;
            m_address_q    <= m_address_d;
            m_burstcount_q <= m_burstcount_d;
            s_readdata_q   <= s_readdata_d;
        end
    end

    // Line data and tags are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign s_waitrequest = (state_q != RESP);
    assign s_readdata    = s_readdata_q;
    assign m_read        = m_read_q;
    assign m_address     = m_address_q;
    assign m_burstcount  = m_burstcount_q;
endmodule

// File: tb/tb_icache_line_ctrl.sv
// Bench for icache_line_ctrl: CPU driver, memory responder and a per-cycle timeline/cache model.
module tb_icache_line_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        invalidate;
    logic [31:0] m_address;
    logic        m_read;
    logic [7:0]  m_burstcount;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    icache_line_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .invalidate     (invalidate),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_burstcount   (m_burstcount),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    logic        exp_wait = 1'b1;
    logic        exp_mread = 1'b0;
    logic [31:0] exp_maddr = '0;
    logic [31:0] exp_data  = '0;
    logic [31:0] rdata_seen;
    logic [31:0] maddr_seen;
    int          n_bursts = 0;
    logic        mread_prev = 1'b0;

    // Cache model: 4 sets, 2 words per line, tag = addr[31:5].
    bit   [3:0]  mvalid = '0;
    logic [26:0] mtag [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hAAAA_0000;
        if (a == 32'h0000_0104) return 32'hBBBB_0004;
        return {a[15:0] ^ 16'h5EED, a[15:0]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[a[4:3]] && (mtag[a[4:3]] == a[31:5]);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_waitrequest", 32'(s_waitrequest), 32'(exp_wait));
            check("m_read", 32'(m_read), 32'(exp_mread));
            if (exp_mread) begin
                check("m_address", m_address, exp_maddr);
                check("m_burstcount", 32'(m_burstcount), 32'd2);
            end
            if (!exp_wait) begin
                check("s_readdata", s_readdata, exp_data);
                rdata_seen = s_readdata;
            end
            if (m_read) maddr_seen = m_address;
            if (m_read && !mread_prev) n_bursts++;
            mread_prev = m_read;
        end
    end

    // One CPU read from IDLE back to IDLE; the memory side answers with the given stall/gap.
    task automatic read_txn(input logic [31:0] a, input int stall, input int gap,
                            input int inval_beat, output bit miss,
                            output logic [31:0] rdata, output logic [31:0] maddr);
        logic [31:0] line;
        line       = {a[31:3], 3'b000};
        miss       = !model_hit(a);
        exp_data   = mem_rd({a[31:2], 2'b00});
        exp_maddr  = line;
        rdata_seen = 'x;
        maddr_seen = 'x;
        s_read     = 1'b1;
        s_address  = a;
        exp_wait   = 1'b1;
        exp_mread  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (miss) begin
            exp_mread = 1'b1;
            for (int k = 0; k <= stall; k++) begin
                m_waitrequest = (k < stall);
                @(posedge clk); #1;
            end
            m_waitrequest = 1'b0;
            exp_mread     = 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
                m_readdatavalid = 1'b1;
                m_readdata      = mem_rd(line + 32'(4 * b));
                invalidate      = (b == inval_beat);
                @(posedge clk); #1;
                m_readdatavalid = 1'b0;
                invalidate      = 1'b0;
            end
            mvalid[a[4:3]] = 1'b1;
            mtag[a[4:3]]   = a[31:5];
            if (inval_beat >= 0) mvalid = '0;
        end
        exp_wait = 1'b0;
        @(posedge clk); #1;
        s_read   = 1'b0;
        exp_wait = 1'b1;
        rdata    = rdata_seen;
        maddr    = maddr_seen;
    endtask

    task automatic inval_idle();
        invalidate = 1'b1;
        exp_wait   = 1'b1;
        exp_mread  = 1'b0;
        @(posedge clk); #1;
        invalidate = 1'b0;
        mvalid     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_waitrequest"}, 32'(s_waitrequest), 32'd1);
        check({tag, "_m_read"}, 32'(m_read), 32'd0);
        check({tag, "_m_address"}, m_address, 32'd0);
        check({tag, "_m_burstcount"}, 32'(m_burstcount), 32'd0);
        check({tag, "_s_readdata"}, s_readdata, 32'd0);
    endtask

    initial begin
        bit          miss;
        bit          got;
        logic [31:0] rd;
        logic [31:0] ma;
        int          b0;

        reset_n = 1'b0; s_address = '0; s_read = 1'b0; invalidate = 1'b0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(posedge clk); #1;

        b0 = n_bursts;
        read_txn(32'h0000_0104, 0, 0, -1, miss, rd, ma);
        check("cold_miss", 32'(miss), 32'd1);
        check("cold_maddr", ma, 32'h0000_0100);
        check("cold_data", rd, 32'hBBBB_0004);
        read_txn(32'h0000_0100, 0, 0, -1, miss, rd, ma);
        check("hit_is_hit", 32'(miss), 32'd0);
        check("hit_data", rd, 32'hAAAA_0000);
        check("hit_no_new_burst", 32'(n_bursts - b0), 32'd1);

        read_txn(32'h0000_0120, 0, 0, -1, miss, rd, ma);
        check("conflict_miss", 32'(miss), 32'd1);
        check("conflict_maddr", ma, 32'h0000_0120);
        read_txn(32'h0000_0100, 0, 1, -1, miss, rd, ma);
        check("evicted_miss", 32'(miss), 32'd1);
        check("evicted_data", rd, 32'hAAAA_0000);

        b0 = n_bursts;
        read_txn(32'h0000_010C, 5, 2, -1, miss, rd, ma);
        check("stall_miss", 32'(miss), 32'd1);
        check("stall_maddr", ma, 32'h0000_0108);
        check("stall_data", rd, 32'h5FE1_010C);
        check("stall_one_burst", 32'(n_bursts - b0), 32'd1);
        read_txn(32'h0000_0108, 0, 0, -1, miss, rd, ma);
        check("line1_hit", 32'(miss), 32'd0);
        check("line1_hit_data", rd, 32'h5FE5_0108);
        read_txn(32'h0000_0110, 0, 0, -1, miss, rd, ma);

        read_txn(32'h0000_0128, 0, 1, 0, miss, rd, ma);
        check("inval_fill_miss", 32'(miss), 32'd1);
        check("inval_fill_data", rd, mem_rd(32'h0000_0128));
        read_txn(32'h0000_0128, 0, 0, -1, miss, rd, ma);
        check("inval_same_line_miss", 32'(miss), 32'd1);
        read_txn(32'h0000_0110, 0, 0, -1, miss, rd, ma);
        check("inval_line2_miss", 32'(miss), 32'd1);
        read_txn(32'h0000_0100, 0, 0, -1, miss, rd, ma);
        check("inval_line0_miss", 32'(miss), 32'd1);

        read_txn(32'h0000_0118, 0, 0, 1, miss, rd, ma);
        read_txn(32'h0000_0118, 0, 0, -1, miss, rd, ma);
        check("inval_last_beat_miss", 32'(miss), 32'd1);

        read_txn(32'h0000_0100, 0, 0, -1, miss, rd, ma);
        inval_idle();
        read_txn(32'h0000_0100, 0, 0, -1, miss, rd, ma);
        check("inval_idle_miss", 32'(miss), 32'd1);
        read_txn(32'h0000_0104, 0, 0, -1, miss, rd, ma);
        read_txn(32'h0000_0100, 0, 0, -1, miss, rd, ma);
        check("b2b_hit", 32'(miss), 32'd0);

        // Reset in the middle of a refill of line 1.
        chk_en    = 1'b0;
        s_read    = 1'b1;
        s_address = 32'h0000_0108;
        got       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (m_read) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_saw_m_read", 32'(got), 32'd1);
        @(posedge clk); #1;
        m_readdatavalid = 1'b1;
        m_readdata      = mem_rd(32'h0000_0108);
        @(posedge clk); #1;
        reset_n    = 1'b0;
        s_read     = 1'b0;
        m_readdata = mem_rd(32'h0000_010C);
        @(posedge clk); #1;
        check_reset_outputs("rst_in");
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_outputs("rst_out");
        @(posedge clk); #1;
        m_readdatavalid = 1'b0;
        check_reset_outputs("rst_late_beat");
        mvalid    = '0;
        exp_wait  = 1'b1;
        exp_mread = 1'b0;
        mread_prev = 1'b0;
        chk_en    = 1'b1;
        @(posedge clk); #1;

        b0 = n_bursts;
        read_txn(32'h0000_0108, 0, 0, -1, miss, rd, ma);
        check("post_rst_miss", 32'(miss), 32'd1);
        check("post_rst_maddr", ma, 32'h0000_0108);
        check("post_rst_data", rd, 32'h5FE5_0108);
        check("post_rst_one_burst", 32'(n_bursts - b0), 32'd1);
        read_txn(32'h0000_010C, 0, 0, -1, miss, rd, ma);
        check("post_rst_hit", 32'(miss), 32'd0);
        check("post_rst_hit_data", rd, 32'h5FE1_010C);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
